// File: rtl/uart_pkg.sv
// Shared types for the uart_tx arbiter: sequencer states and byte width.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request after ptr wins, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;

  // Scan from farthest to nearest, so the nearest valid request after ptr overwrites the rest.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = N; i >= 1; i--) begin
      idx = IW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        gnt_idx = idx;
        any     = 1'b1;
      end
    end
    gnt_onehot = any ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter/sequencer sharing one uart_tx serializer between NUM_REQ producers.
// Optional WAIT_BUSY watchdog with err_timeout port is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        tx_start,
  output logic [BYTE_W-1:0]           tx_data,
  input  logic                        tx_busy,
  output logic                        active
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                        err_timeout
`endif
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t           state, state_n;
  logic [IW-1:0]        ptr, ptr_n;
  logic [IW-1:0]        grant_n;
  logic [BYTE_W-1:0]    data_n;
  logic [BYTE_W-1:0]    sel_data;
  logic [NUM_REQ-1:0]   ready_n;
  logic                 start_n;
  logic                 active_n;
  logic [NUM_REQ-1:0]   gnt_onehot;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_any;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]        cnt, cnt_n;
  logic                 err_n;
`endif

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req        (req_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_onehot[i]) sel_data = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  // Pulses (ready/start/err) default low, so they last exactly one cycle after being set.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    grant_n  = grant_id;
    data_n   = tx_data;
    ready_n  = '0;
    start_n  = 1'b0;
    active_n = active;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_n    = cnt;
    err_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (gnt_any && !tx_busy) begin
          data_n   = sel_data;
          ready_n  = gnt_onehot;
          grant_n  = gnt_idx;
          ptr_n    = gnt_idx;
          active_n = 1'b1;
          start_n  = 1'b1;
          state_n  = ISSUE;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_n    = '0;
`endif
        end
      end
      ISSUE: begin
        state_n = WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_n   = cnt + CW'(1);
`endif
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_n = WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        // cnt tracks cycles since the start pulse; the byte is abandoned and ptr kept.
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          err_n    = 1'b1;
          active_n = 1'b0;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
`endif
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          active_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= IW'(NUM_REQ - 1);
      grant_id  <= '0;
      tx_data   <= '0;
      req_ready <= '0;
      tx_start  <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      grant_id  <= grant_n;
      tx_data   <= data_n;
      req_ready <= ready_n;
      tx_start  <= start_n;
      active    <= active_n;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      err_timeout <= err_n;
    end
  end
`endif

endmodule
